fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the async FIFO write domain. It shares one FIFO write port (`winc`/`wdata`, back-pressured by `wfull` from the write-pointer/full logic) among `NUM_REQ` requesters. Ownership is granted in bursts of up to `MAX_BURST` words, and priority rotates fairly. It sits entirely in the `wclk` domain, directly in front of the FIFO write interface.

---
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Grants last up to MAX_BURST words; every release costs one IDLE bubble cycle.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wfull,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               owner_req;
    logic               release_now;

    // First requester at or above rr_ptr, wrapping explicitly for non-power-of-2 counts.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel   = rr_ptr;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // gnt is one-hot on the owner during BURST, so it doubles as the datapath select.
    always_comb begin
        ack       = gnt & req & {NUM_REQ{~wfull}};
        winc      = |ack;
        owner_req = |(gnt & req);
        busy      = (state == BURST);
        wdata     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        gnt_nxt      = gnt;
        release_now  = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = BURST;
                    owner_nxt    = sel;
                    beat_cnt_nxt = '0;
                    gnt_nxt      = '0;
                    gnt_nxt[sel] = 1'b1;
                end
            end
            BURST: begin
                if (winc) begin
                    if (beat_cnt == LAST_BEAT) begin
                        release_now = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end else if (!owner_req) begin
                    release_now = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (release_now) begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            gnt      <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance are each checked every
// cycle against an integer-level ownership model, with directed phases followed by random traffic.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    // Stimulus per instance: index 0 is NUM_REQ=4, index 1 is NUM_REQ=3.
    logic [3:0]    req [2];
    logic [DW-1:0] dat [2][4];
    logic          wf  [2];

    logic [3:0]    ack4, gnt4;
    logic [2:0]    ack3, gnt3;
    logic          winc4, winc3, busy4, busy3;
    logic [DW-1:0] wdata4, wdata3;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut4 (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req[0]),
        .req_data ({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
        .wfull    (wf[0]),
        .ack      (ack4),
        .gnt      (gnt4),
        .winc     (winc4),
        .wdata    (wdata4),
        .busy     (busy4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut3 (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req[1][2:0]),
        .req_data ({dat[1][2], dat[1][1], dat[1][0]}),
        .wfull    (wf[1]),
        .ack      (ack3),
        .gnt      (gnt3),
        .winc     (winc3),
        .wdata    (wdata3),
        .busy     (busy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the port, how many words it has sent, and where the scan starts.
    int  nreq    [2] = '{4, 3};
    bit  m_busy  [2];
    int  m_owner [2];
    int  m_sent  [2];
    int  m_ptr   [2];

    bit          chk_en = 1'b0;
    bit          log_en = 1'b0;
    bit          prev_busy [2];
    logic [3:0]  acked [2];
    bit          pend [2][4];
    logic [3:0]  glog [2][$];
    logic [DW-1:0] wlog [$];

    function automatic logic [3:0] exp_gnt(input int d);
        return m_busy[d] ? 4'(1 << m_owner[d]) : 4'b0;
    endfunction

    function automatic logic [3:0] exp_ack(input int d);
        return (m_busy[d] && req[d][m_owner[d]] && !wf[d]) ? exp_gnt(d) : 4'b0;
    endfunction

    task automatic model_step(input int d);
        int n;
        n = nreq[d];
        if (!wrst_n) begin
            m_busy[d] = 0; m_owner[d] = 0; m_sent[d] = 0; m_ptr[d] = 0;
        end else if (!m_busy[d]) begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[d] + k) % n;
                if (req[d][c]) begin
                    m_owner[d] = c; m_busy[d] = 1; m_sent[d] = 0;
                    break;
                end
            end
        end else if (req[d][m_owner[d]] && !wf[d]) begin
            m_sent[d]++;
            if (m_sent[d] == MB) begin
                m_busy[d] = 0;
                m_ptr[d]  = (m_owner[d] + 1) % n;
            end
        end else if (!req[d][m_owner[d]]) begin
            m_busy[d] = 0;
            m_ptr[d]  = (m_owner[d] + 1) % n;
        end
    endtask

    task automatic compare_cycle(input int d);
        logic [3:0]    og, oa, eg, ea;
        logic [DW-1:0] ow, ew;
        logic          ob, oi;
        if (d == 0) begin
            og = gnt4; oa = ack4; ow = wdata4; ob = busy4; oi = winc4;
        end else begin
            og = {1'b0, gnt3}; oa = {1'b0, ack3}; ow = wdata3; ob = busy3; oi = winc3;
        end
        eg = exp_gnt(d);
        ea = exp_ack(d);
        ew = m_busy[d] ? dat[d][m_owner[d]] : '0;
        if (chk_en) begin
            check($sformatf("d%0d_gnt", d),   32'(og), 32'(eg));
            check($sformatf("d%0d_ack", d),   32'(oa), 32'(ea));
            check($sformatf("d%0d_winc", d),  32'(oi), 32'(|ea));
            check($sformatf("d%0d_wdata", d), 32'(ow), 32'(ew));
            check($sformatf("d%0d_busy", d),  32'(ob), 32'(m_busy[d]));
        end
        if (ob && !prev_busy[d]) glog[d].push_back(og);
        prev_busy[d] = ob;
        if (d == 0 && log_en && oi) wlog.push_back(ow);
    endtask

    // Inputs are set just after a falling edge; outputs are compared 1 ns later.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) compare_cycle(d);
        for (int d = 0; d < 2; d++) begin
            acked[d] = exp_ack(d);
            model_step(d);
        end
        @(negedge wclk);
    endtask

    // Requesters hold req/data until acked; in random mode they may abandon a pending word.
    task automatic drive_sources(input bit continuous);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= nreq[d]) begin
                    pend[d][i] = 1'b0;
                end else if (pend[d][i]) begin
                    if (!continuous && $urandom_range(15) == 0) pend[d][i] = 1'b0;
                end else if (continuous || $urandom_range(3) != 0) begin
                    pend[d][i] = 1'b1;
                    dat[d][i]  = DW'($urandom);
                end
                req[d][i] = pend[d][i];
            end
        end
    endtask

    task automatic retire_acked();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (acked[d][i]) pend[d][i] = 1'b0;
    endtask

    task automatic reset_pulse();
        wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        wrst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wf[d] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                dat[d][i] = '0; pend[d][i] = 1'b0;
            end
        end

        // Reset: first edge loads a known state, then outputs must read zero.
        @(negedge wclk);
        tick();
        chk_en = 1'b1;
        tick();
        wrst_n = 1'b1;
        tick();

        // Single requester stream of ten words on requester 1.
        log_en = 1'b1;
        glog[0].delete();
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            req[0]    = 4'b0010;
            dat[0][1] = DW'(8'hA0 + idx);
            req[1]    = '0;
            tick();
            if (acked[0][1]) idx++;
            cyc++;
        end
        req[0] = '0;
        tick();
        tick();
        log_en = 1'b0;
        check("stream_done", 32'(idx), 32'd10);
        check("stream_winc_cnt", 32'(wlog.size()), 32'd10);
        for (int k = 0; k < wlog.size() && k < 10; k++)
            check($sformatf("stream_word%0d", k), 32'(wlog[k]), 32'(8'hA0 + k));
        check("stream_grants", 32'(glog[0].size()), 32'd3);
        foreach (glog[0][k])
            check($sformatf("stream_gnt%0d", k), 32'(glog[0][k]), 32'b0010);

        // All requesters continuous from reset: strict rotation.
        reset_pulse();
        glog[0].delete();
        glog[1].delete();
        for (int c = 0; c < 45; c++) begin
            drive_sources(1'b1);
            tick();
            retire_acked();
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rr_d%0d_count", d), 32'(glog[d].size() >= 8), 32'd1);
            foreach (glog[d][k])
                check($sformatf("rr_d%0d_gnt%0d", d, k), 32'(glog[d][k]), 32'(1 << (k % nreq[d])));
        end

        // Reset during the third beat of owner 2, then priority returns to requester 0.
        cyc = 0;
        while (!(m_busy[0] && m_owner[0] == 2 && m_sent[0] == 2) && cyc < 40) begin
            drive_sources(1'b1);
            tick();
            retire_acked();
            cyc++;
        end
        check("rst_mid_reached", 32'(cyc < 40), 32'd1);
        drive_sources(1'b1);
        reset_pulse();
        retire_acked();
        glog[0].delete();
        glog[1].delete();
        for (int c = 0; c < 6; c++) begin
            drive_sources(1'b1);
            tick();
            retire_acked();
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_regrant", d), 32'(glog[d].size() >= 1), 32'd1);
            if (glog[d].size() >= 1)
                check($sformatf("rst_d%0d_first", d), 32'(glog[d][0]), 32'b0001);
        end

        // Random traffic: abandonment, full stalls, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            drive_sources(1'b0);
            wf[0]  = ($urandom_range(3) == 0);
            wf[1]  = ($urandom_range(3) == 0);
            wrst_n = ($urandom_range(199) != 0);
            tick();
            retire_acked();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
